router_pkt_reader: RTL and testbench
====================================

# router_pkt_reader

Output-port packet reader for the 1x3 router. Drains one router output FIFO through its `read_enb`/`empty`/`data_out` interface, delineates packets (header, payload, parity), checks parity, and presents a framed byte stream with valid/ready backpressure to the downstream consumer. One instance sits behind each of the three output FIFOs. It is the consuming end of the interface the FIFO write side feeds.

## Interface
Parameters:
- `TIMEOUT`, 30: consecutive starved cycles mid-packet before the packet is aborted (range 2..255).
- `CNT_W`, 16: width of the packet and error counters.

Ports (clock and reset first):
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data_out`  in  8  FIFO read data, valid the cycle after a read is accepted.
- `fifo_read_enb`  out  1  FIFO read request.
- `out_data`  out  8  byte to the consumer.
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  consumer accepts the beat.
- `out_sop`  out  1  beat is a header.
- `out_eop`  out  1  beat is the parity byte, or the synthetic abort beat.
- `out_err`  out  1  valid with `out_eop` only: parity mismatch or timeout.
- `timeout_pulse`  out  1  one-cycle pulse when a packet is aborted.
- `pkt_count`  out  CNT_W  completed packets (eop beats accepted), saturating.
- `err_count`  out  CNT_W  eop beats accepted with err set, saturating.

## Operation
- Packet format: header byte `{len[5:0], addr[1:0]}`, then `len` payload bytes (0..63), then a parity byte. Parity equals the XOR of the header and all payload bytes.
- Read issue: `fifo_read_enb = !fifo_empty && (occ + inflight − pop) < 2`.
  - `occ` is skid occupancy (0..2).
  - `inflight` is a registered flag meaning a read was issued last cycle.
  - `pop = out_valid && out_ready`.
  - `out_ready` reaches `fifo_read_enb` combinationally; this path is accepted.
  - The block never issues a read while `fifo_empty` is high.
- Framing FSM advances on each arriving byte (cycle after the read):
  - HDR: capture `len`, set `remain = len`, load `acc = byte`, tag sop, go to BODY. If `len == 0`, go to PAR instead.
  - BODY: `acc ^= byte`, decrement `remain`; when `remain` reaches 0, go to PAR.
  - PAR: tag eop, set `err = (byte != acc)`, return to HDR.
- Timeout:
  - In BODY or PAR, `starve` counts cycles with no arriving byte and `fifo_empty` high. Any arrival clears it. It is 0 in HDR.
  - When `starve == TIMEOUT − 1` and the skid has a free slot, inject a synthetic beat `{data 8'h00, eop, err}`, pulse `timeout_pulse`, and go to HDR.
  - If the skid is full, injection waits; `starve` holds at its limit.
- Skid buffer: 2-entry FIFO of `{data, sop, eop, err}`. The head drives the `out_*` signals. Beats leave only on `pop`, in arrival order, and are never dropped or duplicated.
- Counters: on `pop && out_eop`, increment `pkt_count`. If `out_err` is also set, increment `err_count`. Both saturate at all-ones.

## Timing
- Reset values: every output is 0, the FSM is in HDR, and `occ`, `inflight`, `starve`, `acc`, `remain` are 0. A read in flight when reset asserts is discarded. Reset mid-packet makes the next arriving byte a header.
- Latency: a read issued in cycle N delivers the byte into the skid at the end of N+1, with `out_valid` high in N+2.
- Throughput: with the FIFO non-empty and `out_ready` held high, one beat per cycle is sustained.
- While `out_valid` is high and `out_ready` is low, all `out_*` fields hold stable.
- Packets may follow back-to-back: the header arrives the cycle after the parity byte with no bubble.
- Push and pop in the same cycle with `occ == 2` is legal, and `occ` stays 2.
- `timeout_pulse` coincides with the cycle the synthetic beat enters the skid.

## Structure
- `router_pkg` holds:
  - the header field positions (`ADDR_LSB=0`, `LEN_LSB=2`, `LEN_W=6`);
  - the FSM enum (`HDR`, `BODY`, `PAR`);
  - the beat struct `{data, sop, eop, err}`.
- Sub-module `router_skid_buf`: the 2-entry beat FIFO exposing `occ`. Framing, timeout and counters stay in the top module.

## Test plan
- Reset: assert `reset` for 2 cycles with the FIFO non-empty. Required: all outputs 0, `fifo_read_enb` 0 during reset, counters 0.
- Good packet: send `0E 11 22 33 0E` with `out_ready=1`. Required: 5 consecutive beats, sop on `0E`, eop on the last beat with err=0, first `out_valid` 2 cycles after the first read, `pkt_count=1`.
- Bad parity: send `0E 11 22 33 FF`. Required: eop beat `FF` with err=1, `err_count=1`, `pkt_count=1`.
- Backpressure: send a 20-byte packet with `out_ready` low for 10 cycles mid-packet. Required: `fifo_read_enb` low while the skid is full, data held stable, all bytes delivered in order, no loss.
- Timeout: with `TIMEOUT=8`, send header `10` (len 4) plus 2 payload bytes, then leave the FIFO empty. Required: after 8 starved cycles a beat `00` with eop=1 and err=1, `timeout_pulse` for one cycle; the next byte written is treated as sop.
- Edge mix: send a len-0 packet `01 01` back-to-back with a len-63 packet, then reset mid-payload. Required: correct framing, no bubble between packets, and a clean restart at HDR after reset.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the router output-port packet reader: header layout,
// framing states and the beat carried through the skid buffer.
package router_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_LSB = 0;
  localparam int unsigned LEN_LSB  = 2;
  localparam int unsigned LEN_W    = 6;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    BODY = 2'd1,
    PAR  = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic              err;
  } beat_t;

  function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] hdr);
    return hdr[LEN_LSB +: LEN_W];
  endfunction

endpackage

// File: rtl/router_skid_buf.sv
// Two-entry beat FIFO between the framing logic and the consumer; the head
// entry drives the output beat and leaves only on an accepted pop.
module router_skid_buf
  import router_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  beat_t      i_beat,
  input  logic       i_pop,
  output beat_t      o_head,
  output logic       o_valid,
  output logic [1:0] o_occ
);

  beat_t       r_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_occ;
  logic        w_pop;

  assign o_valid = (r_occ != 2'd0);
  assign o_occ   = r_occ;
  assign w_pop   = i_pop && o_valid;
  // Idle head reads as all-zero so sop/eop/err never linger without valid.
  assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;

  // A push at full occupancy is only legal together with a pop: it reuses the slot being freed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_beat;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: rtl/router_pkt_reader.sv
// Output-port packet reader: drains a router FIFO, frames header/payload/parity,
// checks parity, aborts starved packets and presents a valid/ready byte stream.
module router_pkt_reader
  import router_pkg::*;
#(
  parameter int unsigned TIMEOUT = 30,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data_out,
  output logic              fifo_read_enb,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic              out_err,
  output logic              timeout_pulse,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam int unsigned        STARVE_W   = 8;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(TIMEOUT - 1);

  rd_state_e           r_state, w_state_nxt;
  logic [LEN_W-1:0]    r_remain, w_remain_nxt;
  logic [DATA_W-1:0]   r_acc, w_acc_nxt;
  logic [STARVE_W-1:0] r_starve, w_starve_nxt;
  logic                r_inflight;
  logic [CNT_W-1:0]    r_pkt_count, r_err_count;

  logic                w_push, w_inject, w_pop, w_valid;
  beat_t               w_push_beat, w_head;
  logic [1:0]          w_occ;
  logic [2:0]          w_load;
  logic [LEN_W-1:0]    w_len;

  router_skid_buf u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_beat  (w_push_beat),
    .i_pop   (out_ready),
    .o_head  (w_head),
    .o_valid (w_valid),
    .o_occ   (w_occ)
  );

  assign w_pop = w_valid && out_ready;
  assign w_len = hdr_len(fifo_data_out);
  // Synthetic beats also take a skid slot, so they count against the read budget.
  assign w_load        = 3'(w_occ) + 3'(r_inflight) + 3'(w_inject);
  assign fifo_read_enb = !reset && !fifo_empty && (w_load < (3'd2 + 3'(w_pop)));

  assign out_data      = w_head.data;
  assign out_valid     = w_valid;
  assign out_sop       = w_head.sop;
  assign out_eop       = w_head.eop;
  assign out_err       = w_head.err;
  assign timeout_pulse = w_inject;
  assign pkt_count     = r_pkt_count;
  assign err_count     = r_err_count;

  // Framing advances on each arriving byte; starvation only counts mid-packet.
  always_comb begin
    w_state_nxt  = r_state;
    w_remain_nxt = r_remain;
    w_acc_nxt    = r_acc;
    w_starve_nxt = r_starve;
    w_push       = 1'b0;
    w_push_beat  = '0;
    w_inject     = 1'b0;
    if (r_inflight) begin
      w_push           = 1'b1;
      w_push_beat.data = fifo_data_out;
      w_starve_nxt     = '0;
      unique case (r_state)
        HDR: begin
          w_push_beat.sop = 1'b1;
          w_acc_nxt       = fifo_data_out;
          w_remain_nxt    = w_len;
          w_state_nxt     = (w_len == '0) ? PAR : BODY;
        end
        BODY: begin
          w_acc_nxt    = r_acc ^ fifo_data_out;
          w_remain_nxt = r_remain - LEN_W'(1);
          if (r_remain == LEN_W'(1)) w_state_nxt = PAR;
        end
        PAR: begin
          w_push_beat.eop = 1'b1;
          w_push_beat.err = (fifo_data_out != r_acc);
          w_state_nxt     = HDR;
        end
        default: w_state_nxt = HDR;
      endcase
    end else if (r_state != HDR) begin
      if (r_starve == STARVE_MAX) begin
        if (w_occ < 2'd2) begin
          w_inject        = 1'b1;
          w_push          = 1'b1;
          w_push_beat.eop = 1'b1;
          w_push_beat.err = 1'b1;
          w_state_nxt     = HDR;
          w_starve_nxt    = '0;
        end
      end else if (fifo_empty) begin
        w_starve_nxt = r_starve + STARVE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= HDR;
      r_remain    <= '0;
      r_acc       <= '0;
      r_starve    <= '0;
      r_inflight  <= 1'b0;
      r_pkt_count <= '0;
      r_err_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_remain   <= w_remain_nxt;
      r_acc      <= w_acc_nxt;
      r_starve   <= w_starve_nxt;
      r_inflight <= fifo_read_enb;
      if (w_pop && w_head.eop) begin
        if (r_pkt_count != '1) r_pkt_count <= r_pkt_count + CNT_W'(1);
        if (w_head.err && (r_err_count != '1)) r_err_count <= r_err_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_router_pkt_reader.sv
// Scoreboard bench for router_pkt_reader: a byte-FIFO model feeds packets and
// expected beats are queued at stimulus time and compared on each accepted beat.
module tb_router_pkt_reader;
  import router_pkg::*;

  localparam int unsigned TO = 8;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_empty;
  logic [7:0]    fifo_data_out = 8'h00;
  logic          fifo_read_enb;
  logic [7:0]    out_data;
  logic          out_valid, out_ready, out_sop, out_eop, out_err, timeout_pulse;
  logic [CW-1:0] pkt_count, err_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] fifo_mem [1024];
  logic [9:0] wr_ptr = 10'd0;
  logic [9:0] rd_ptr = 10'd0;
  logic       flush_req = 1'b0;
  int         underflows = 0;

  beat_t      exp_q [$];
  int         exp_pkt = 0;
  int         exp_err = 0;
  logic [7:0] pl [64];

  router_pkt_reader #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_read_enb (fifo_read_enb),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sop       (out_sop),
    .out_eop       (out_eop),
    .out_err       (out_err),
    .timeout_pulse (timeout_pulse),
    .pkt_count     (pkt_count),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  // Router FIFO model: read data appears the cycle after an accepted read.
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (flush_req) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_read_enb) begin
      if (fifo_empty) underflows <= underflows + 1;
      fifo_data_out <= fifo_mem[rd_ptr];
      rd_ptr        <= rd_ptr + 10'd1;
    end
  end

  function automatic beat_t mk(input logic [7:0] d, input logic s, input logic e, input logic r);
    beat_t b;
    b.data = d; b.sop = s; b.eop = e; b.err = r;
    return b;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    fifo_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 10'd1;
  endtask

  // Writes a whole packet from pl[] and queues the beats it must produce.
  task automatic send_pkt(input logic [1:0] addr, input logic [5:0] len,
                          input logic force_par, input logic [7:0] par_val);
    logic [7:0] hdr, acc, par;
    hdr = {len, addr};
    acc = hdr;
    push_byte(hdr);
    exp_q.push_back(mk(hdr, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < int'(len); i++) begin
      acc = acc ^ pl[i];
      push_byte(pl[i]);
      exp_q.push_back(mk(pl[i], 1'b0, 1'b0, 1'b0));
    end
    par = force_par ? par_val : acc;
    push_byte(par);
    exp_q.push_back(mk(par, 1'b0, 1'b1, par != acc));
    exp_pkt++;
    if (par != acc) exp_err++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    out_ready = 1'b0;
    push_byte(8'h0E);
    push_byte(8'h11);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      if (c == 1) flush_req = 1'b1;
      checks++;
      if (fifo_read_enb !== 1'b0) begin
        failures++; $display("FAIL reset_read_enb cyc=%0d got=%b exp=0", c, fifo_read_enb);
      end
      checks++;
      if ({out_valid, out_sop, out_eop, out_err, out_data, timeout_pulse} !== 13'h0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got v=%b s=%b e=%b r=%b d=%h tp=%b exp all 0",
                 c, out_valid, out_sop, out_eop, out_err, out_data, timeout_pulse);
      end
      checks++;
      if ({pkt_count, err_count} !== '0) begin
        failures++; $display("FAIL reset_counters got pkt=%0d err=%0d exp 0/0", pkt_count, err_count);
      end
    end
    @(negedge clk);
    flush_req = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || fifo_read_enb !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle got v=%b rd=%b exp 0/0", out_valid, fifo_read_enb);
    end
  endtask

  task automatic test_good();
    int first_rd, first_v, first_pop, last_pop, npop;
    beat_t got, exp;
    first_rd = -1; first_v = -1; first_pop = -1; last_pop = -1; npop = 0;
    out_ready = 1'b1;
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    @(negedge clk);
    send_pkt(2'd2, 6'd3, 1'b0, 8'h00);
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
      #1;
      if (fifo_read_enb && first_rd < 0) first_rd = c;
      if (out_valid && first_v < 0) first_v = c;
      if (out_valid && out_ready) begin
        got = mk(out_data, out_sop, out_eop, out_err);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
          failures++; $display("FAIL good_beat got=%h/%b%b%b exp=%h/%b%b%b",
                               got.data, got.sop, got.eop, got.err, exp.data, exp.sop, exp.eop, exp.err);
        end
        if (first_pop < 0) first_pop = c;
        last_pop = c;
        npop++;
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL good_drain_timeout left=%0d exp 0", exp_q.size()); exp_q.delete();
    end
    checks++;
    if (first_v - first_rd != 2) begin
      failures++; $display("FAIL good_latency got=%0d exp=2", first_v - first_rd);
    end
    checks++;
    if (npop != 5 || last_pop - first_pop != 4) begin
      failures++; $display("FAIL good_back_to_back got beats=%0d span=%0d exp 5/4", npop, last_pop - first_pop);
    end
    checks++;
    if (pkt_count !== CW'(exp_pkt) || err_count !== CW'(exp_err)) begin
      failures++; $display("FAIL good_counters got=%0d/%0d exp=%0d/%0d", pkt_count, err_count, exp_pkt, exp_err);
    end
  endtask

  task automatic test_bad_parity();
    beat_t got, exp;
    out_ready = 1'b1;
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    @(negedge clk);
    send_pkt(2'd2, 6'd3, 1'b1, 8'hFF);
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
      #1;
      if (out_valid && out_ready) begin
        got = mk(out_data, out_sop, out_eop, out_err);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
          failures++; $display("FAIL bad_beat got=%h/%b%b%b exp=%h/%b%b%b",
                               got.data, got.sop, got.eop, got.err, exp.data, exp.sop, exp.eop, exp.err);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL bad_drain_timeout left=%0d exp 0", exp_q.size()); exp_q.delete();
    end
    checks++;
    if (pkt_count !== CW'(exp_pkt) || err_count !== CW'(exp_err)) begin
      failures++; $display("FAIL bad_counters got=%0d/%0d exp=%0d/%0d", pkt_count, err_count, exp_pkt, exp_err);
    end
  endtask

  task automatic test_backpressure();
    beat_t got, exp, held;
    int npop;
    npop = 0;
    held = '0;
    for (int i = 0; i < 18; i++) pl[i] = 8'($urandom_range(0, 255));
    @(negedge clk);
    send_pkt(2'd1, 6'd18, 1'b0, 8'h00);
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
      out_ready = !(c >= 5 && c < 15);
      #1;
      got = mk(out_data, out_sop, out_eop, out_err);
      if (c == 5) held = got;
      if (c > 5 && c < 15) begin
        checks++;
        if (out_valid !== 1'b1 || got !== held) begin
          failures++; $display("FAIL bp_hold cyc=%0d got v=%b %h exp v=1 %h", c, out_valid, got.data, held.data);
        end
        checks++;
        if (fifo_read_enb !== 1'b0) begin
          failures++; $display("FAIL bp_read_enb cyc=%0d got=%b exp=0", c, fifo_read_enb);
        end
      end
      if (out_valid && out_ready) begin
        exp = exp_q.pop_front();
        npop++;
        checks++;
        if (got !== exp) begin
          failures++; $display("FAIL bp_beat idx=%0d got=%h/%b%b%b exp=%h/%b%b%b", npop,
                               got.data, got.sop, got.eop, got.err, exp.data, exp.sop, exp.eop, exp.err);
        end
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    checks++;
    if (npop != 20 || exp_q.size() != 0) begin
      failures++; $display("FAIL bp_count got=%0d exp=20", npop); exp_q.delete();
    end
  endtask

  task automatic test_timeout();
    beat_t got, exp;
    int npulse, pulse_c;
    npulse = 0; pulse_c = -1;
    out_ready = 1'b1;
    @(negedge clk);
    push_byte(8'h10); push_byte(8'hA1); push_byte(8'hB2);
    exp_q.push_back(mk(8'h10, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(8'hA1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(8'hB2, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(8'h00, 1'b0, 1'b1, 1'b1));
    exp_pkt++; exp_err++;
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      #1;
      if (timeout_pulse) begin npulse++; pulse_c = c; end
      if (out_valid && out_ready) begin
        got = mk(out_data, out_sop, out_eop, out_err);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
          failures++; $display("FAIL to_beat got=%h/%b%b%b exp=%h/%b%b%b",
                               got.data, got.sop, got.eop, got.err, exp.data, exp.sop, exp.eop, exp.err);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL to_drain_timeout left=%0d exp 0", exp_q.size()); exp_q.delete();
    end
    checks++;
    if (npulse != 1 || pulse_c != 11) begin
      failures++; $display("FAIL to_pulse got count=%0d cyc=%0d exp 1/11", npulse, pulse_c);
    end
    pl[0] = 8'h5A;
    send_pkt(2'd0, 6'd1, 1'b0, 8'h00);
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      #1;
      if (timeout_pulse) npulse++;
      if (out_valid && out_ready) begin
        got = mk(out_data, out_sop, out_eop, out_err);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
          failures++; $display("FAIL to_next_sop got=%h/%b%b%b exp=%h/%b%b%b",
                               got.data, got.sop, got.eop, got.err, exp.data, exp.sop, exp.eop, exp.err);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (npulse != 1 || exp_q.size() != 0 || pkt_count !== CW'(exp_pkt) || err_count !== CW'(exp_err)) begin
      failures++; $display("FAIL to_after got pulses=%0d left=%0d cnt=%0d/%0d exp 1/0/%0d/%0d",
                           npulse, exp_q.size(), pkt_count, err_count, exp_pkt, exp_err);
      exp_q.delete();
    end
  endtask

  task automatic test_edge_mix();
    beat_t got, exp;
    int npop, last_pop, gaps;
    npop = 0; last_pop = -1; gaps = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 63; i++) pl[i] = 8'($urandom_range(0, 255));
    @(negedge clk);
    send_pkt(2'd1, 6'd0, 1'b0, 8'h00);
    send_pkt(2'd2, 6'd63, 1'b0, 8'h00);
    for (int c = 0; c < 80 && npop < 20; c++) begin
      #1;
      if (out_valid && out_ready) begin
        got = mk(out_data, out_sop, out_eop, out_err);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
          failures++; $display("FAIL edge_beat idx=%0d got=%h/%b%b%b exp=%h/%b%b%b", npop,
                               got.data, got.sop, got.eop, got.err, exp.data, exp.sop, exp.eop, exp.err);
        end
        if (last_pop >= 0 && c != last_pop + 1) gaps++;
        last_pop = c;
        npop++;
      end
      @(negedge clk);
    end
    checks++;
    if (npop != 20 || gaps != 0) begin
      failures++; $display("FAIL edge_no_bubble got beats=%0d gaps=%0d exp 20/0", npop, gaps);
    end
    reset = 1'b1;
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_pkt = 0; exp_err = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || pkt_count !== '0 || err_count !== '0) begin
      failures++; $display("FAIL edge_reset got v=%b cnt=%0d/%0d exp 0/0/0", out_valid, pkt_count, err_count);
    end
    @(negedge clk);
    pl[0] = 8'hA5; pl[1] = 8'h3C;
    send_pkt(2'd0, 6'd2, 1'b0, 8'h00);
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      #1;
      if (out_valid && out_ready) begin
        got = mk(out_data, out_sop, out_eop, out_err);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
          failures++; $display("FAIL edge_restart got=%h/%b%b%b exp=%h/%b%b%b",
                               got.data, got.sop, got.eop, got.err, exp.data, exp.sop, exp.eop, exp.err);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0 || pkt_count !== CW'(exp_pkt) || err_count !== CW'(exp_err)) begin
      failures++; $display("FAIL edge_restart_cnt got left=%0d cnt=%0d/%0d exp 0/%0d/%0d",
                           exp_q.size(), pkt_count, err_count, exp_pkt, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_parity();
    test_backpressure();
    test_timeout();
    test_edge_mix();
    checks++;
    if (underflows != 0) begin
      failures++; $display("FAIL read_while_empty got=%0d exp=0", underflows);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
